gray_seq_ctrl: RTL and testbench
================================

# gray_seq_ctrl

Sequencing controller for the N-bit Gray counter. It owns the counter's `clk_en` and active-low reset inputs, issues a programmed number of enable pulses at a programmable rate, and reports completion with a one-cycle `done` pulse. An optional checker watches the counter output for illegal multi-bit transitions. The block sits between the lab's command/register logic and the Gray counter instance.

## Interface
- `N`, 4: Gray counter output width; must match the counter instance.
- `STEP_W`, 8: width of the step-count field.
- `DIV_W`, 8: width of the prescaler field.

- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `clear` in 1: reinitialise the counter; sampled only in IDLE.
- `abort` in 1: terminate a run; sampled only in RUN.
- `steps` in STEP_W: number of enable pulses for the run; latched on accepted `start`.
- `div` in DIV_W: pulse period minus 1, in cycles; latched on accepted `start`.
- `gray_in` in N: counter output, used by the checker.
- `cnt_en` out 1: drives the counter `clk_en`; registered.
- `cnt_rst` out 1: drives the counter reset (active-low); registered.
- `busy` out 1: high in RUN and CLR.
- `done` out 1: one-cycle pulse when a run completes normally.
- `steps_left` out STEP_W: pulses still to issue.
- `err` out 1: sticky checker flag; tied to 0 without the macro.

## Operation
- FSM states: IDLE, CLR, RUN, DONE. Reset puts the FSM in IDLE.
- Output reset values: `cnt_en`=0, `cnt_rst`=1, `busy`=0, `done`=0, `steps_left`=0, `err`=0.
- IDLE with `clear`=1 goes to CLR. `clear` has priority over a simultaneous `start`.
- IDLE with `start`=1 and `steps`≠0 goes to RUN. It latches `div` into the prescaler and `steps` into `steps_left`.
- IDLE with `start`=1 and `steps`=0 goes to DONE. No enable pulse is issued.
- CLR: `cnt_rst`=0 for exactly 2 cycles, then the FSM returns to IDLE. No `done` pulse. `err` is cleared.
- RUN, prescaler behaviour:
  - The prescaler decrements each cycle.
  - When it reaches 0, `cnt_en` is high for the following cycle, the prescaler reloads the latched `div`, and `steps_left` decrements.
  - With `div`=0, `cnt_en` is high on every cycle.
- RUN exit on completion: when `steps_left` reaches 0, the FSM goes to DONE after that final pulse cycle.
- RUN exit on abort: `abort`=1 goes to IDLE at the next edge. From that edge `cnt_en`=0, even if a pulse was due. No `done` pulse. `steps_left` holds its remaining value.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `start`/`clear` outside IDLE and `abort` outside RUN are ignored.
- Arithmetic: the prescaler and step counter are unsigned, with no wrap. The maximum run is (2^STEP_W − 1) pulses at period 2^DIV_W.

## Timing
- Edge E samples `start` (FSM in IDLE).
- First `cnt_en` high cycle begins at edge E+1+div.
- Pulses are spaced div+1 cycles apart.
- Last pulse begins at edge E+steps·(div+1).
- `done` is high in the cycle beginning at edge E+steps·(div+1)+1.
- `busy` rises at E+1 and falls when `done` rises.
- Counter state updates at the edge closing each `cnt_en` cycle. `gray_in` reflects the change one cycle after `cnt_en`.
- Asynchronous `rst` mid-run: all outputs take their reset values immediately, including `cnt_en`=0 and `cnt_rst`=1. The counter is not reset by this block in that case; it shares `rst`.

## Configuration
- Macro `GRAY_SEQ_CHECK_EN`.
- Defined, per-pulse check:
  - The checker samples `gray_in` two cycles after each `cnt_en` cycle.
  - It compares the sample with the previous one.
  - A Hamming distance greater than 1 sets `err`.
- Defined, post-clear check: one cycle after CLR exits, `gray_in` must equal 1 followed by N−1 zeros; otherwise `err` is set.
- `err` is sticky until CLR or `rst`.
- Not defined: no checker logic is built and `err` is constant 0.

## Test plan
- Reset then `clear`: `cnt_rst`=0 for 2 cycles, `busy`=1 for 2 cycles, then IDLE; `gray_in`=4'b1000 with N=4.
- `start` with steps=5, div=2: `cnt_en` pulses at E+3, E+6, E+9, E+12, E+15; `done` at E+16; `steps_left` ends at 0.
- `start` with steps=0: no `cnt_en`; `done` at E+1.
- steps=10, div=0, `abort` at the edge after the 4th pulse: exactly 4 pulses issued; `steps_left`=6; no `done`; `busy` low next cycle.
- `start` and `clear` in the same cycle: CLR taken, no pulses. `start` during RUN: ignored, and the original pulse count completes.
- With `GRAY_SEQ_CHECK_EN`, bench forces `gray_in` 0000→0011 after a pulse: `err`=1 and it holds through a later normal run until `clear`.

Source files
------------

// File: rtl/gray_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gray_seq_ctrl_if
// Description : Bundle between the command/register logic (master) and the
//               Gray-counter sequencing controller (slave).
//               Command side : start, clear, abort, steps, div
//               Counter side : gray_in (counter output), cnt_en, cnt_rst
//               Status side  : busy, done, steps_left, err
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_seq_ctrl_if #(
    parameter int N      = 4,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
);
    logic              start;
    logic              clear;
    logic              abort;
    logic [STEP_W-1:0] steps;
    logic [DIV_W-1:0]  div;
    logic [N-1:0]      gray_in;
    logic              cnt_en;
    logic              cnt_rst;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;
    logic              err;

    modport master (
        output start, clear, abort, steps, div, gray_in,
        input  cnt_en, cnt_rst, busy, done, steps_left, err
    );

    modport slave (
        input  start, clear, abort, steps, div, gray_in,
        output cnt_en, cnt_rst, busy, done, steps_left, err
    );
endinterface
`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gray_seq_ctrl
// Description : Sequencing controller for an N-bit Gray counter. Issues a
//               programmed number of clk_en pulses at a programmable period,
//               pulses done on normal completion, and can reset the counter.
//               Optional transition checker enabled by `GRAY_SEQ_CHECK_EN.
// Ports       : clk  - system clock
//               rst  - asynchronous, active-low reset
//               bus  - gray_seq_ctrl_if.slave (command, counter, status)
// Revision    : 1.0 - initial release
// ============================================================================
module gray_seq_ctrl #(
    parameter int N      = 4,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input  wire            clk,
    input  wire            rst,
    gray_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_presc, w_presc_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [STEP_W-1:0] r_steps_left, w_steps_left_nxt;
    logic              r_cnt_en, w_cnt_en_nxt;
    logic              r_cnt_rst, w_cnt_rst_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_clr_phase, w_clr_phase_nxt;
    logic              w_clr_exit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_div        <= '0;
            r_steps_left <= '0;
            r_cnt_en     <= 1'b0;
            r_cnt_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_clr_phase  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_div        <= w_div_nxt;
            r_steps_left <= w_steps_left_nxt;
            r_cnt_en     <= w_cnt_en_nxt;
            r_cnt_rst    <= w_cnt_rst_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_clr_phase  <= w_clr_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_presc_nxt      = r_presc;
        w_div_nxt        = r_div;
        w_steps_left_nxt = r_steps_left;
        w_cnt_en_nxt     = 1'b0;
        w_cnt_rst_nxt    = 1'b1;
        w_clr_phase_nxt  = 1'b0;
        w_clr_exit       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt   = ST_CLR;
                    w_cnt_rst_nxt = 1'b0;
                end else if (bus.start) begin
                    w_div_nxt        = bus.div;
                    w_presc_nxt      = bus.div;
                    w_steps_left_nxt = bus.steps;
                    w_state_nxt      = (bus.steps != '0) ? ST_RUN : ST_DONE;
                end
            end

            // Counter reset is held low for the entry cycle and one more.
            ST_CLR: begin
                if (r_clr_phase) begin
                    w_state_nxt = ST_IDLE;
                    w_clr_exit  = 1'b1;
                end else begin
                    w_clr_phase_nxt = 1'b1;
                    w_cnt_rst_nxt   = 1'b0;
                end
            end

            // DONE is entered together with the final pulse so that the
            // registered done output lands right after that pulse cycle.
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_presc == '0) begin
                    w_cnt_en_nxt     = 1'b1;
                    w_presc_nxt      = r_div;
                    w_steps_left_nxt = r_steps_left - STEP_W'(1);
                    if (r_steps_left == STEP_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_presc_nxt = r_presc - DIV_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // busy tracks the CLR window exactly and covers a run up to its last
        // pulse; it drops on the same edge that takes the run back to IDLE.
        w_busy_nxt = (w_state_nxt == ST_CLR) ||
                     ((r_state == ST_RUN) && (w_state_nxt != ST_IDLE));
        w_done_nxt = (r_state == ST_DONE);
    end

    assign bus.cnt_en     = r_cnt_en;
    assign bus.cnt_rst    = r_cnt_rst;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.steps_left = r_steps_left;

`ifdef GRAY_SEQ_CHECK_EN
    localparam logic [N-1:0] c_GRAY_RST = {1'b1, {(N-1){1'b0}}};

    logic         r_en_d1;
    logic         r_clr_exit_d;
    logic         r_err;
    logic [N-1:0] r_prev;
    logic [N-1:0] w_diff;
    logic         w_multi;

    // More than one set bit in the XOR means an illegal Gray step.
    assign w_diff  = bus.gray_in ^ r_prev;
    assign w_multi = (w_diff & (w_diff - N'(1))) != '0;

    // A pulse in cycle T updates the counter at edge T+1; the sample is
    // taken at edge T+2, when gray_in has settled on the new code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_d1      <= 1'b0;
            r_clr_exit_d <= 1'b0;
            r_err        <= 1'b0;
            r_prev       <= c_GRAY_RST;
        end else begin
            r_en_d1      <= r_cnt_en;
            r_clr_exit_d <= w_clr_exit;
            if (r_state == ST_CLR) begin
                r_err <= 1'b0;
            end else if (r_clr_exit_d) begin
                r_prev <= bus.gray_in;
                if (bus.gray_in != c_GRAY_RST) begin
                    r_err <= 1'b1;
                end
            end else if (r_en_d1) begin
                r_prev <= bus.gray_in;
                if (w_multi) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.err = r_err;
`else
    logic [N:0] w_unused_chk;
    assign w_unused_chk = {bus.gray_in, w_clr_exit};
    assign bus.err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gray_seq_ctrl
// Description : Scoreboard bench for gray_seq_ctrl. Commands push the
//               expected run outcome; a monitor closes each transaction on
//               done or a falling busy and compares against it. A small
//               binary-counter model supplies gray_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_seq_ctrl;
    localparam int N      = 4;
    localparam int STEP_W = 8;
    localparam int DIV_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gray_seq_ctrl_if #(.N(N), .STEP_W(STEP_W), .DIV_W(DIV_W)) bus ();

    gray_seq_ctrl #(.N(N), .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: reset code 1000 is gray(1111), so count in binary.
    logic [N-1:0] bin;
    logic         force_en  = 1'b0;
    logic [N-1:0] force_val = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst)                bin <= '1;
        else if (!bus.cnt_rst)   bin <= '1;
        else if (bus.cnt_en)     bin <= bin + N'(1);
    end
    assign bus.gray_in = force_en ? force_val : (bin ^ (bin >> 1));

    typedef struct {
        int e_end;
        int pulses;
        int first;
        int last;
        bit done;
        int left;
        int rstlow;
        int busy;
        int period;
    } exp_t;

    exp_t q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   events     = 0;
    int   exp_events = 0;
    int   model_left = 0;
    bit   exp_err    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int   n_pulse = 0, first_p = 0, last_p = 0, rstlow = 0, busyc = 0;
    bit   spacing_bad = 1'b0;
    bit   busy_d = 1'b0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                n_pulse = 0; rstlow = 0; busyc = 0; spacing_bad = 1'b0; busy_d = 1'b0;
                continue;
            end
            if (bus.cnt_en === 1'b1) begin
                if (n_pulse == 0) first_p = cyc;
                else if (q.size() > 0 && (cyc - last_p) != q[0].period) spacing_bad = 1'b1;
                last_p = cyc;
                n_pulse++;
            end
            if (bus.cnt_rst === 1'b0) rstlow++;
            if (bus.busy === 1'b1) busyc++;
            if (bus.done === 1'b1 || (busy_d && bus.busy !== 1'b1)) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: done=%0b busy=%0b at cycle %0d, required no event", bus.done, bus.busy, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("end_cycle", cyc, mon_e.e_end);
                    chk("done", bus.done, mon_e.done);
                    chk("pulses", n_pulse, mon_e.pulses);
                    if (mon_e.pulses > 0) begin
                        chk("first_pulse", first_p, mon_e.first);
                        chk("last_pulse", last_p, mon_e.last);
                        chk("spacing", spacing_bad, 0);
                    end
                    chk("steps_left", bus.steps_left, mon_e.left);
                    chk("rst_low_cycles", rstlow, mon_e.rstlow);
                    chk("busy_cycles", busyc, mon_e.busy);
                end
                n_pulse = 0; rstlow = 0; busyc = 0; spacing_bad = 1'b0;
                events++;
            end
            busy_d = (bus.busy === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_events(input int budget);
        int n = 0;
        while (events < exp_events && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (events < exp_events) begin
            checks++; errors++;
            $display("FAIL timeout: events=%0d required=%0d", events, exp_events);
            q.delete();
            events = exp_events;
        end
    endtask

    task automatic idle_and_check_err();
        repeat (4) @(negedge clk);
        chk("err", bus.err, exp_err);
    endtask

    task automatic do_run(input int st, input int dv, input int ab_k, input bit mid);
        exp_t e;
        int   E;
        if ($urandom_range(0, 1) == 1) begin
            bus.abort = 1'b1;                  // ignored outside RUN
            @(negedge clk);
            bus.abort = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.steps = STEP_W'(st);
        bus.div   = DIV_W'(dv);
        E = cyc + 1;
        e.period = dv + 1;
        if (ab_k > 0) begin
            e.pulses = ab_k; e.done = 1'b0; model_left = st - ab_k;
        end else begin
            e.pulses = st;   e.done = 1'b1; model_left = 0;
        end
        e.e_end  = E + e.pulses * (dv + 1) + 1;
        e.busy   = e.pulses * (dv + 1);
        e.first  = E + 1 + dv;
        e.last   = E + e.pulses * (dv + 1);
        e.left   = model_left;
        e.rstlow = 0;
        q.push_back(e);
        exp_events++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.steps = STEP_W'($urandom);
        bus.div   = DIV_W'($urandom);
        if (mid && st > 0) begin
            bus.start = 1'b1;                  // ignored in RUN
            bus.clear = 1'b1;
            bus.steps = STEP_W'($urandom_range(1, 255));
            @(negedge clk);
            bus.start = 1'b0;
            bus.clear = 1'b0;
        end
        if (ab_k > 0) begin
            while (cyc < E + ab_k * (dv + 1)) @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
        end
        wait_events(st * (dv + 1) + 20);
        idle_and_check_err();
    endtask

    task automatic do_clear(input bit with_start);
        exp_t e;
        int   C;
        @(negedge clk);
        bus.clear = 1'b1;
        if (with_start) begin
            bus.start = 1'b1;
            bus.steps = STEP_W'(7);
            bus.div   = DIV_W'(0);
        end
        C = cyc + 1;
        e.e_end = C + 2; e.pulses = 0; e.first = 0; e.last = 0; e.done = 1'b0;
        e.left = model_left; e.rstlow = 2; e.busy = 2; e.period = 1;
        q.push_back(e);
        exp_events++;
        exp_err = 1'b0;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        wait_events(20);
        idle_and_check_err();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, dv, ab;
        bus.start = 1'b0; bus.clear = 1'b0; bus.abort = 1'b0;
        bus.steps = '0;   bus.div   = '0;
        repeat (3) @(negedge clk);
        chk("rst_cnt_en", bus.cnt_en, 0);
        chk("rst_cnt_rst", bus.cnt_rst, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_steps_left", bus.steps_left, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_clear(1'b0);
        do_run(5, 2, 0, 1'b0);
        do_run(0, 3, 0, 1'b0);
        do_run(10, 0, 4, 1'b0);
        do_clear(1'b1);
        do_run(6, 1, 0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            st = $urandom_range(0, 12);
            dv = $urandom_range(0, 4);
            ab = 0;
            if (st >= 2 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, st - 1);
            do_run(st, dv, ab, 1'($urandom_range(0, 1)));
        end

        do_run(255, 0, 0, 1'b0);
        do_run(2, 255, 0, 1'b0);

        // Asynchronous reset in the middle of a div=0 run.
        @(negedge clk);
        bus.start = 1'b1; bus.steps = STEP_W'(20); bus.div = DIV_W'(0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_cnt_en", bus.cnt_en, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_cnt_en", bus.cnt_en, 0);
        chk("async_cnt_rst", bus.cnt_rst, 1);
        chk("async_busy", bus.busy, 0);
        chk("async_done", bus.done, 0);
        chk("async_steps_left", bus.steps_left, 0);
        model_left = 0;
        exp_err = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_err", bus.err, 0);

        // Illegal 0000 -> 0011 transition observed after a pulse.
        do_clear(1'b0);
        do_run(1, 0, 0, 1'b0);
        force_val = 4'b0011;
        force_en  = 1'b1;
`ifdef GRAY_SEQ_CHECK_EN
        exp_err = 1'b1;
`endif
        do_run(1, 0, 0, 1'b0);
        force_en = 1'b0;
        do_run(3, 1, 0, 1'b0);
        do_clear(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
